// File: rtl/lcd_st_pkg.sv
// Shared types and constants for the LCD Avalon-ST channel adapter.
package lcd_st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } adapter_state_e;

    typedef struct packed {
        logic sop;
        logic eop;
    } st_frame_t;

    localparam int unsigned SKID_DEPTH = 2;

    // Packed beat layout is {data, channel, frame}.
    function automatic int unsigned beat_width(input int unsigned data_w, input int unsigned ch_w);
        return data_w + ch_w + $bits(st_frame_t);
    endfunction

endpackage

// File: rtl/lcd_st_channel_adapter_if.sv
// Avalon-ST channelised link with ready/valid handshake and packet framing.
interface lcd_st_channel_adapter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CH_W   = 8
);
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   channel;
    logic              sop;
    logic              eop;

    modport master (output valid, output data, output channel, output sop, output eop, input  ready);
    modport slave  (input  valid, input  data, input  channel, input  sop, input  eop, output ready);
endinterface

// File: rtl/lcd_st_skid_buffer.sv
// Two-entry ready/valid register slice; in_ready is registered and never
// depends combinationally on out_ready.
module lcd_st_skid_buffer
    import lcd_st_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0]      ent_q [SKID_DEPTH];
    logic [WIDTH-1:0]      ent_d [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] vld_q;
    logic [SKID_DEPTH-1:0] vld_d;
    logic                  push;
    logic                  pop;

    assign push      = in_valid && in_ready;
    assign pop       = vld_q[0] && out_ready;
    assign out_valid = vld_q[0];
    assign out_data  = ent_q[0];

    // Entry 0 is the head presented downstream; entry 1 absorbs the in-flight beat.
    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (pop) begin
            ent_d[0] = ent_q[1];
            vld_d    = vld_q >> 1;
        end
        if (push) begin
            if (!vld_d[0]) begin
                ent_d[0] = in_data;
                vld_d[0] = 1'b1;
            end else begin
                ent_d[1] = in_data;
                vld_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            vld_q    <= '0;
            in_ready <= 1'b0;
        end else begin
            ent_q    <= ent_d;
            vld_q    <= vld_d;
            in_ready <= !vld_d[SKID_DEPTH-1];
        end
    end

endmodule

// File: rtl/lcd_st_channel_adapter.sv
// Rebases channel numbers, discards whole packets outside the sink's channel
// range, counts discards, and registers the result through a skid buffer.
module lcd_st_channel_adapter
    import lcd_st_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_CH_W  = 8,
    parameter int unsigned OUT_CH_W = 1,
    parameter int unsigned CH_BASE  = 0,
    parameter int unsigned MAX_CH   = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lcd_st_channel_adapter_if.slave  in_st,
    lcd_st_channel_adapter_if.master out_st,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     drop_clear
);

    localparam int unsigned RANGE_W = 33;
    localparam int unsigned BEAT_W  = beat_width(DATA_W, OUT_CH_W);

    adapter_state_e      state_q;
    adapter_state_e      state_d;
    logic [OUT_CH_W-1:0] pkt_ch_q;
    logic [OUT_CH_W-1:0] pkt_ch_d;

    logic [IN_CH_W-1:0]  in_ch;
    logic [RANGE_W-1:0]  ch_diff;
    logic                in_range;
    logic [OUT_CH_W-1:0] ch_rebased;
    logic                accept;
    logic                pass_beat;
    logic                drop_inc;
    logic [OUT_CH_W-1:0] beat_ch;

    st_frame_t           in_frame;
    st_frame_t           out_frame;
    logic [BEAT_W-1:0]   buf_in;
    logic [BEAT_W-1:0]   buf_out;
    logic                buf_in_ready;
    logic                buf_out_valid;

    // Widened subtraction: a borrow means the channel is below the base.
    assign in_ch      = in_st.channel;
    assign ch_diff    = RANGE_W'(in_ch) - RANGE_W'(CH_BASE);
    assign in_range   = !ch_diff[RANGE_W-1] && (ch_diff[RANGE_W-2:0] <= (RANGE_W-1)'(MAX_CH));
    assign ch_rebased = OUT_CH_W'(ch_diff);
    assign accept     = in_st.valid && buf_in_ready;

    // SOP and orphan beats are judged on their own channel; packet bodies follow the SOP decision.
    always_comb begin
        state_d   = state_q;
        pkt_ch_d  = pkt_ch_q;
        pass_beat = 1'b0;
        drop_inc  = 1'b0;
        beat_ch   = ch_rebased;
        if (in_st.sop || state_q == ST_IDLE) begin
            pass_beat = in_range;
            drop_inc  = accept && !in_range;
        end else begin
            pass_beat = (state_q == ST_PASS);
            beat_ch   = pkt_ch_q;
        end
        if (accept) begin
            if (in_st.sop) begin
                pkt_ch_d = ch_rebased;
                if (in_st.eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = in_range ? ST_PASS : ST_DROP;
                end
            end else if (in_st.eop) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pkt_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            pkt_ch_q <= pkt_ch_d;
        end
    end

    // Saturating drop counter; clear takes priority over a coincident drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_clear) begin
            drop_count <= '0;
        end else if (drop_inc && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign in_frame = '{sop: in_st.sop, eop: in_st.eop};
    assign buf_in   = {in_st.data, beat_ch, in_frame};

    lcd_st_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_st.valid && pass_beat),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in),
        .out_valid (buf_out_valid),
        .out_ready (out_st.ready),
        .out_data  (buf_out)
    );

    assign in_st.ready  = buf_in_ready;
    assign out_st.valid = buf_out_valid;
    assign {out_st.data, out_st.channel, out_frame} = buf_out;
    assign out_st.sop   = out_frame.sop;
    assign out_st.eop   = out_frame.eop;

endmodule

// File: tb/tb_lcd_st_channel_adapter.sv
// Directed and randomised-backpressure bench for lcd_st_channel_adapter
// (CH_BASE=2, MAX_CH=1, CNT_W=2).
module tb_lcd_st_channel_adapter;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IN_CH_W  = 8;
    localparam int unsigned OUT_CH_W = 1;
    localparam int unsigned CH_BASE  = 2;
    localparam int unsigned MAX_CH   = 1;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned OBS_W    = DATA_W + OUT_CH_W + 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             drop_clear = 1'b0;
    logic [CNT_W-1:0] drop_count;

    lcd_st_channel_adapter_if #(.DATA_W(DATA_W), .CH_W(IN_CH_W))  in_if ();
    lcd_st_channel_adapter_if #(.DATA_W(DATA_W), .CH_W(OUT_CH_W)) out_if ();

    lcd_st_channel_adapter #(
        .DATA_W   (DATA_W),
        .IN_CH_W  (IN_CH_W),
        .OUT_CH_W (OUT_CH_W),
        .CH_BASE  (CH_BASE),
        .MAX_CH   (MAX_CH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_st      (in_if),
        .out_st     (out_if),
        .drop_count (drop_count),
        .drop_clear (drop_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic             drv_pass = 1'b0;
    logic [0:0]       drv_exp_ch = 1'b0;
    bit               rand_ready = 1'b0;
    bit               chk_ready_en = 1'b0;
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] hold_beat;
    bit               hold_v = 1'b0;
    int               occ = 0;
    int               win_pops = 0;
    int               win_gaps = 0;
    int               last_pop_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_if.ready = 1'($urandom_range(0, 1));
    end

    // Samples just before each rising edge: scoreboard, stability and ready/occupancy checks.
    always @(negedge clk) begin
        #4;
        if (!reset_n) begin
            exp_q.delete();
            occ    = 0;
            hold_v = 1'b0;
        end else begin
            obs = {out_if.data, out_if.channel, out_if.sop, out_if.eop};
            if (hold_v) begin
                check_eq("out_stable", 32'(obs), 32'(hold_beat));
                check_eq("out_valid_held", 32'(out_if.valid), 32'd1);
            end
            hold_v    = out_if.valid && !out_if.ready;
            hold_beat = obs;
            if (chk_ready_en) check_eq("in_ready_vs_occ", 32'(in_if.ready), 32'(occ != 2));
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_out", 32'(exp_q.size()), 32'd1);
                else check_eq("out_beat", 32'(obs), 32'(exp_q.pop_front()));
                if (win_pops > 0 && cyc != last_pop_cyc + 1) win_gaps++;
                win_pops++;
                last_pop_cyc = cyc;
                occ--;
            end
            if (in_if.valid && in_if.ready && drv_pass) begin
                exp_q.push_back({in_if.data, drv_exp_ch, in_if.sop, in_if.eop});
                occ++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance with valid still high.
    task automatic send_beat(input logic [7:0] d, input logic [7:0] ch, input logic sop,
                             input logic eop, input logic pass, input logic exp_ch);
        int waited = 0;
        in_if.data    = d;
        in_if.channel = ch;
        in_if.sop     = sop;
        in_if.eop     = eop;
        in_if.valid   = 1'b1;
        drv_pass      = pass;
        drv_exp_ch    = exp_ch;
        while (!in_if.ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_if.ready) begin
            check_eq("accept_timeout", 32'(in_if.ready), 32'd1);
            in_if.valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        in_if.valid = 1'b0;
        drv_pass    = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        drop_clear = 1'b1;
        @(negedge clk);
        drop_clear = 1'b0;
        check_eq("clear", 32'(drop_count), 32'd0);
    endtask

    initial begin
        int t0;
        int beats;
        int ch, len;
        logic pass;
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        in_if.valid = 1'b0; in_if.data = '0; in_if.channel = '0;
        in_if.sop = 1'b0; in_if.eop = 1'b0; out_if.ready = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_ready",  32'(in_if.ready),    32'd0);
        check_eq("rst_out_valid", 32'(out_if.valid),   32'd0);
        check_eq("rst_out_data",  32'(out_if.data),    32'd0);
        check_eq("rst_out_ch",    32'(out_if.channel), 32'd0);
        check_eq("rst_out_sop",   32'(out_if.sop),     32'd0);
        check_eq("rst_out_eop",   32'(out_if.eop),     32'd0);
        check_eq("rst_drops",     32'(drop_count),     32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(in_if.ready), 32'd1);
        chk_ready_en = 1'b1;
        out_if.ready = 1'b1;

        // Channels 2,3 pass as 0,1 at full rate; channel 4 is dropped.
        t0 = cyc; win_pops = 0; win_gaps = 0;
        for (int p = 2; p <= 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                send_beat(8'(p * 16 + b), 8'(p), b == 0, b == 3, p != 4, 1'(p - 2));
                if (p == 2 && b == 0) begin
                    check_eq("latency_valid", 32'(out_if.valid),   32'd1);
                    check_eq("latency_data",  32'(out_if.data),    32'h20);
                    check_eq("latency_ch",    32'(out_if.channel), 32'd0);
                end
            end
        end
        check_eq("t1_in_cycles", 32'(cyc - t0), 32'd12);
        go_idle();
        wait_drain();
        check_eq("t1_pops",  32'(win_pops),   32'd8);
        check_eq("t1_gaps",  32'(win_gaps),   32'd0);
        check_eq("t1_drops", 32'(drop_count), 32'd1);

        // Decision and channel latched at SOP despite later channel 7.
        send_beat(8'hA0, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int b = 1; b < 4; b++) send_beat(8'(8'hA0 + b), 8'd7, 1'b0, b == 3, 1'b1, 1'b0);
        go_idle();
        wait_drain();
        check_eq("t2_drops", 32'(drop_count), 32'd1);

        // Missing EOP: dropped fragment on ch 9, then a new packet on ch 2.
        pulse_clear();
        send_beat(8'hB0, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        send_beat(8'hB1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(8'hB2, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        send_beat(8'hB3, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        send_beat(8'hB4, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        go_idle();
        wait_drain();
        check_eq("t4_drops", 32'(drop_count), 32'd1);

        // Counter saturation at 3, then clear beating a coincident drop.
        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            send_beat(8'(8'hD0 + k), 8'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            go_idle();
            check_eq("sat_drops", 32'(drop_count), 32'(exp_sat[k]));
        end
        drop_clear = 1'b1;
        send_beat(8'hD8, 8'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        go_idle();
        drop_clear = 1'b0;
        check_eq("clear_wins", 32'(drop_count), 32'd0);
        send_beat(8'hE0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        go_idle();
        check_eq("orphan_drop", 32'(drop_count), 32'd1);
        send_beat(8'hE1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        go_idle();
        wait_drain();
        check_eq("orphan_pass_drops", 32'(drop_count), 32'd1);

        // Random backpressure over well-formed packets with idle gaps.
        rand_ready = 1'b1;
        beats = 0;
        while (beats < 1000) begin
            ch   = int'($urandom_range(0, 5));
            len  = int'($urandom_range(1, 4));
            pass = (ch >= 2 && ch <= 3);
            for (int b = 0; b < len; b++) begin
                send_beat(8'($urandom_range(0, 255)),
                          (b == 0) ? 8'(ch) : 8'($urandom_range(0, 9)),
                          b == 0, b == len - 1, pass, 1'(ch - 2));
                beats++;
                if ($urandom_range(0, 3) == 0) begin
                    go_idle();
                    @(negedge clk);
                end
            end
        end
        go_idle();
        wait_drain();
        rand_ready = 1'b0;
        @(negedge clk);
        out_if.ready = 1'b0;

        // Reset while the buffer is full and a packet is in progress.
        send_beat(8'hF0, 8'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_drops", 32'(drop_count != 0), 32'd1);
        send_beat(8'hC0, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        send_beat(8'hC1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        in_if.data = 8'hC2; in_if.sop = 1'b0; in_if.eop = 1'b0;
        @(negedge clk);
        check_eq("full_in_ready",  32'(in_if.ready),  32'd0);
        check_eq("full_out_valid", 32'(out_if.valid), 32'd1);
        chk_ready_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid_out_valid", 32'(out_if.valid), 32'd0);
        check_eq("rstmid_in_ready",  32'(in_if.ready),  32'd0);
        check_eq("rstmid_drops",     32'(drop_count),   32'd0);
        go_idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst2", 32'(in_if.ready), 32'd1);
        chk_ready_en = 1'b1;
        out_if.ready = 1'b1;
        // A body beat after reset is an orphan, so FSM must have returned to IDLE.
        send_beat(8'hC3, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        go_idle();
        check_eq("post_rst_orphan", 32'(drop_count), 32'd1);
        send_beat(8'h50, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        send_beat(8'h51, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        send_beat(8'h52, 8'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        go_idle();
        wait_drain();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_st_channel_adapter.md
# lcd_st_channel_adapter

Parametrised Avalon-ST channel adapter for the LCD Qsys fabric, placed between a channelised source (e.g. bytes-to-packets converter) and a sink with fewer channels. It rebases the incoming channel number by a configurable offset, discards whole packets whose channel falls outside the sink's range, and counts discarded packets. Output is registered through a two-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `DATA_W`, 8, payload width in bits.
- `IN_CH_W`, 8, input channel width.
- `OUT_CH_W`, 1, output channel width (≥1).
- `CH_BASE`, 0, lowest accepted input channel; subtracted from `in_channel`.
- `MAX_CH`, 0, highest accepted output channel (rebased); must be < 2^OUT_CH_W.
- `CNT_W`, 16, drop counter width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_ready`  out  1  sink-side ready to upstream.
- `in_valid`  in  1  beat valid.
- `in_data`  in  DATA_W  payload.
- `in_channel`  in  IN_CH_W  source channel.
- `in_startofpacket`, `in_endofpacket`  in  1 each  packet framing.
- `out_ready`  in  1  downstream ready.
- `out_valid`  out  1  beat valid.
- `out_data`  out  DATA_W  payload.
- `out_channel`  out  OUT_CH_W  rebased channel, in_channel − CH_BASE truncated.
- `out_startofpacket`, `out_endofpacket`  out  1 each  framing, passed through.
- `drop_count`  out  CNT_W  saturating count of dropped packets.
- `drop_clear`  in  1  synchronous clear of `drop_count`.

## Operation
- Accept: beat transfers on `in_valid && in_ready`.
- Range check (full IN_CH_W compare, no truncation): pass iff CH_BASE ≤ in_channel ≤ CH_BASE+MAX_CH.
- FSM states IDLE, PASS, DROP; reset to IDLE.
  - IDLE, SOP beat: in range → PASS, else → DROP; SOP+EOP same beat stays IDLE (decision applies to that beat only).
  - PASS/DROP: decision latched at SOP and held for all beats to EOP, regardless of later `in_channel`; EOP beat → IDLE.
  - SOP received in PASS/DROP (missing EOP): treated as new packet, re-evaluated as from IDLE.
  - Beat without SOP in IDLE (orphan): evaluated per beat, no state change.
- Dropped beats: consumed (`in_ready` still governs acceptance) but never written to skid buffer.
- `drop_count` increments by 1 per dropped SOP beat and per dropped orphan beat; saturates at 2^CNT_W−1; `drop_clear` wins over a simultaneous increment (result 0).
- Skid buffer: 2 entries holding {data, channel, sop, eop}; `in_ready` = buffer not full (registered); `out_valid` = buffer not empty.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`/`out_channel`/`out_startofpacket`/`out_endofpacket`=0, `drop_count`=0, FSM=IDLE, buffer empty.
- `in_ready` rises first rising edge after `reset_n` deasserts.
- Latency: accepted passed beat appears on `out_*` the cycle after acceptance.
- Full throughput (1 beat/cycle) while `out_ready`=1.
- `out_ready` deassert: buffer absorbs one in-flight beat; `in_ready` drops the next cycle; no beat lost or duplicated.
- Output stable while `out_valid && !out_ready`.
- Simultaneous push and pop on full buffer: not possible (`in_ready`=0); on 1-entry: occupancy unchanged.
- Reset mid-packet: buffer flushed, FSM IDLE, partial packet discarded, counter cleared.

## Structure
- Package `lcd_st_pkg`: FSM state enum (IDLE/PASS/DROP), beat record struct width helper, skid-depth constant 2.
- Sub-module `lcd_st_skid_buffer` (parameter WIDTH): 2-entry ready/valid register slice; adapter packs payload+channel+framing into one vector.

## Test plan
- CH_BASE=2, MAX_CH=1: packets on channels 2,3,4 (4 beats each) with `out_ready`=1 → channels 2,3 emerge as out_channel 0,1 at 1 beat/cycle; channel 4 packet absent; `drop_count`=1.
- Packet starting on channel 2 whose later beats carry channel 7 → all 4 beats passed with out_channel 0.
- Random `out_ready` toggling (50%) over 1000 beats → output sequence identical to filtered input, no loss/duplication, `in_ready` low only when buffer full.
- SOP in channel 9 followed by SOP (no EOP) in channel 2 → first fragment dropped, second packet passed, `drop_count`=1.
- CNT_W=2, five dropped single-beat packets → `drop_count` 1,2,3,3,3; `drop_clear` with a coincident drop → 0.
- Assert `reset_n` low mid-packet with buffer full → `out_valid`=0 and `in_ready`=0 immediately; after release, new packet passes cleanly.
